// File: rtl/depth_sched_pkg.sv
// Shared types and width helpers for the disparity sweep controller.
// Contents:
//   state_t  - sequencer state (IDLE, SWEEP)
//   cnt_w()  - counter width for a modulus, never less than 1 bit
//   DEF_*    - default geometry and the counter widths derived from it
package depth_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Width needed to hold 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_MAX_DISP = 16;
    localparam int unsigned DEF_H_ACTIVE = 320;
    localparam int unsigned DEF_V_ACTIVE = 240;

    localparam int unsigned DEF_DISP_W = cnt_w(DEF_MAX_DISP);
    localparam int unsigned DEF_H_W    = cnt_w(DEF_H_ACTIVE);
    localparam int unsigned DEF_V_W    = cnt_w(DEF_V_ACTIVE);

endpackage

// File: rtl/disparity_sweep_ctrl_wrap_counter.sv
// wrap_counter: modulo-MAX_COUNT up counter with terminal-count decodes.
// Ports:
//   clk_in, rst_n_in - clock, async active-low reset
//   inc_in           - advance by one, wrapping to 0 from MAX_COUNT-1
//   clr_in           - synchronous clear, wins over inc_in
//   count_out        - current count
//   at_max_out       - count == MAX_COUNT-1
//   at_almost_out    - count == MAX_COUNT-2 (never set when MAX_COUNT < 2)
module wrap_counter
    import depth_sched_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 16,
    parameter int unsigned W         = cnt_w(MAX_COUNT)
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         inc_in,
    input  logic         clr_in,
    output logic [W-1:0] count_out,
    output logic         at_max_out,
    output logic         at_almost_out
);

    localparam int unsigned LAST   = (MAX_COUNT >= 1) ? MAX_COUNT - 1 : 0;
    localparam int unsigned ALMOST = (MAX_COUNT >= 2) ? MAX_COUNT - 2 : 0;
    localparam bit          HAS_ALMOST = (MAX_COUNT >= 2);

    assign at_max_out    = (count_out == W'(LAST));
    assign at_almost_out = HAS_ALMOST && (count_out == W'(ALMOST));

    // Count register: clear first, then wrap-or-increment.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_out <= '0;
        end else if (clr_in) begin
            count_out <= '0;
        end else if (inc_in) begin
            count_out <= at_max_out ? '0 : count_out + W'(1);
        end
    end

endmodule

// File: rtl/disparity_sweep_ctrl.sv
// disparity_sweep_ctrl: per-pixel disparity sweep sequencer for the stereo
// block-matching cost datapath. Each accepted pixel issues MAX_DISP cost
// requests (disparity 0..MAX_DISP-1) and advances the column/row position.
// Optional build macro: BACK2BACK_EN - accept the next pixel on the final
// request's handshake so sweeps run with no idle bubble.
// Ports:
//   clk_in, rst_n_in        - clock, async active-low reset
//   abort_in                - synchronous abort to IDLE with position zeroed
//   pix_valid_in/ready_out  - pixel ingest handshake
//   cost_req_out/ready_in   - cost request handshake
//   cost_disp/hcount/vcount - disparity and pixel position of the request
//   disp_almost_last_out    - request carries disparity MAX_DISP-2
//   disp_last_out           - request carries disparity MAX_DISP-1
//   line_end_out            - pulse after the last request of a line
//   frame_end_out           - pulse after the last request of a frame
//   busy_out                - sweep in progress
module disparity_sweep_ctrl
    import depth_sched_pkg::*;
#(
    parameter int unsigned MAX_DISP = DEF_MAX_DISP,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          abort_in,
    input  logic                          pix_valid_in,
    output logic                          pix_ready_out,
    output logic                          cost_req_out,
    input  logic                          cost_ready_in,
    output logic [cnt_w(MAX_DISP)-1:0]    cost_disp_out,
    output logic [cnt_w(H_ACTIVE)-1:0]    cost_hcount_out,
    output logic [cnt_w(V_ACTIVE)-1:0]    cost_vcount_out,
    output logic                          disp_almost_last_out,
    output logic                          disp_last_out,
    output logic                          line_end_out,
    output logic                          frame_end_out,
    output logic                          busy_out
);

    localparam int unsigned DISP_W = cnt_w(MAX_DISP);
    localparam int unsigned H_W    = cnt_w(H_ACTIVE);
    localparam int unsigned V_W    = cnt_w(V_ACTIVE);

    state_t state;

    logic accept;
    logic accept_last;
    logic pix_take;
    logic disp_at_max;
    logic disp_at_almost;
    logic h_at_max;
    logic v_at_max;
    logic h_almost_unused;
    logic v_almost_unused;

    // Abort suppresses every handshake in its cycle.
    assign accept      = (state == SWEEP) && cost_ready_in && !abort_in;
    assign accept_last = accept && disp_at_max;

`ifdef BACK2BACK_EN
    assign pix_ready_out = !abort_in &&
                           ((state == IDLE) ||
                            ((state == SWEEP) && disp_at_max && cost_ready_in));
`else
    assign pix_ready_out = !abort_in && (state == IDLE);
`endif

    assign pix_take             = pix_valid_in && pix_ready_out;
    assign cost_req_out         = (state == SWEEP);
    assign busy_out             = (state != IDLE);
    assign disp_last_out        = cost_req_out && disp_at_max;
    assign disp_almost_last_out = cost_req_out && disp_at_almost;

    wrap_counter #(.MAX_COUNT(MAX_DISP), .W(DISP_W)) u_disp (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .inc_in        (accept),
        .clr_in        (abort_in),
        .count_out     (cost_disp_out),
        .at_max_out    (disp_at_max),
        .at_almost_out (disp_at_almost)
    );

    wrap_counter #(.MAX_COUNT(H_ACTIVE), .W(H_W)) u_hcount (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .inc_in        (accept_last),
        .clr_in        (abort_in),
        .count_out     (cost_hcount_out),
        .at_max_out    (h_at_max),
        .at_almost_out (h_almost_unused)
    );

    wrap_counter #(.MAX_COUNT(V_ACTIVE), .W(V_W)) u_vcount (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .inc_in        (accept_last && h_at_max),
        .clr_in        (abort_in),
        .count_out     (cost_vcount_out),
        .at_max_out    (v_at_max),
        .at_almost_out (v_almost_unused)
    );

    // Sequencer state and registered end-of-line/frame pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            line_end_out  <= 1'b0;
            frame_end_out <= 1'b0;
        end else begin
            line_end_out  <= accept_last && h_at_max;
            frame_end_out <= accept_last && h_at_max && v_at_max;
            if (abort_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (pix_take) state <= SWEEP;
                    // pix_take can only be set here with back-to-back enabled.
                    SWEEP:   if (accept_last) state <= pix_take ? SWEEP : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disparity_sweep_ctrl.sv
// Directed bench for disparity_sweep_ctrl with MAX_DISP=4, H_ACTIVE=3,
// V_ACTIVE=2. Honours BACK2BACK_EN when defined for the build.
module tb_disparity_sweep_ctrl;

    localparam int unsigned MAX_DISP = 4;
    localparam int unsigned H_ACTIVE = 3;
    localparam int unsigned V_ACTIVE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic       cost_req;
    logic       cost_ready = 1'b0;
    logic [1:0] disp;
    logic [1:0] hcount;
    logic [0:0] vcount;
    logic       almost_last;
    logic       last;
    logic       line_end;
    logic       frame_end;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    disparity_sweep_ctrl #(
        .MAX_DISP (MAX_DISP),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .abort_in             (abort),
        .pix_valid_in         (pix_valid),
        .pix_ready_out        (pix_ready),
        .cost_req_out         (cost_req),
        .cost_ready_in        (cost_ready),
        .cost_disp_out        (disp),
        .cost_hcount_out      (hcount),
        .cost_vcount_out      (vcount),
        .disp_almost_last_out (almost_last),
        .disp_last_out        (last),
        .line_end_out         (line_end),
        .frame_end_out        (frame_end),
        .busy_out             (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sweep of one pixel with cost_ready high; ends one cycle after
    // the last request is accepted.
    task automatic run_pixel();
        pix_valid  = 1'b1;
        cost_ready = 1'b1;
        step();
        pix_valid = 1'b0;
        repeat (MAX_DISP) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; abort = 1'b0; pix_valid = 1'b0; cost_ready = 1'b0;
        #3;
        n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL reset_pix_ready got %0b want 1", pix_ready); end
        n_cmp++; if (cost_req !== 1'b0) begin n_err++; $display("FAIL reset_cost_req got %0b want 0", cost_req); end
        n_cmp++; if (disp !== 2'd0) begin n_err++; $display("FAIL reset_disp got %0d want 0", disp); end
        n_cmp++; if (hcount !== 2'd0) begin n_err++; $display("FAIL reset_hcount got %0d want 0", hcount); end
        n_cmp++; if (vcount !== 1'd0) begin n_err++; $display("FAIL reset_vcount got %0d want 0", vcount); end
        n_cmp++; if ({almost_last, last} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {almost_last, last}); end
        n_cmp++; if ({line_end, frame_end} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {line_end, frame_end}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        pix_valid  = 1'b1;
        cost_ready = 1'b1;
        #1;
        n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_idle got %0b want 1", pix_ready); end
        step();
        pix_valid = 1'b0;
        for (int d = 0; d < 4; d++) begin
            n_cmp++; if (cost_req !== 1'b1) begin n_err++; $display("FAIL basic_req d%0d got %0b want 1", d, cost_req); end
            n_cmp++; if (disp !== 2'(d)) begin n_err++; $display("FAIL basic_disp got %0d want %0d", disp, d); end
            n_cmp++; if (almost_last !== (d == 2)) begin n_err++; $display("FAIL basic_almost d%0d got %0b", d, almost_last); end
            n_cmp++; if (last !== (d == 3)) begin n_err++; $display("FAIL basic_last d%0d got %0b", d, last); end
            n_cmp++; if (hcount !== 2'd0) begin n_err++; $display("FAIL basic_hcount_hold got %0d want 0", hcount); end
            n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_busy d%0d got %0b want 0", d, pix_ready); end
            step();
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got %0b want 0", busy); end
        n_cmp++; if (cost_req !== 1'b0) begin n_err++; $display("FAIL basic_req_end got %0b want 0", cost_req); end
        n_cmp++; if (hcount !== 2'd1) begin n_err++; $display("FAIL basic_hcount_end got %0d want 1", hcount); end
        n_cmp++; if (line_end !== 1'b0) begin n_err++; $display("FAIL basic_no_line_end got %0b want 0", line_end); end
        n_cmp++; if ({almost_last, last} !== 2'b00) begin n_err++; $display("FAIL basic_flags_idle got %b want 00", {almost_last, last}); end
    endtask

    task automatic test_stall();
        pix_valid  = 1'b1;
        cost_ready = 1'b1;
        step();
        pix_valid = 1'b0;
        step();
        cost_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (disp !== 2'd1) begin n_err++; $display("FAIL stall_disp c%0d got %0d want 1", c, disp); end
            n_cmp++; if (cost_req !== 1'b1) begin n_err++; $display("FAIL stall_req c%0d got %0b want 1", c, cost_req); end
        end
        cost_ready = 1'b1;
        step();
        n_cmp++; if (disp !== 2'd2) begin n_err++; $display("FAIL stall_resume got %0d want 2", disp); end
        step();
        step();
        n_cmp++; if (hcount !== 2'd2 || busy !== 1'b0) begin n_err++; $display("FAIL stall_end got h%0d busy%0b want h2 busy0", hcount, busy); end
        // cost_ready in IDLE must change nothing.
        step();
        n_cmp++; if (disp !== 2'd0 || hcount !== 2'd2 || busy !== 1'b0) begin n_err++; $display("FAIL idle_ready_ignored got d%0d h%0d b%0b want d0 h2 b0", disp, hcount, busy); end
    endtask

    task automatic test_stream();
        test_reset();
        for (int k = 1; k <= 6; k++) begin
            run_pixel();
            n_cmp++; if (line_end !== (k % 3 == 0)) begin n_err++; $display("FAIL stream_line_end px%0d got %0b want %0b", k, line_end, (k % 3 == 0)); end
            n_cmp++; if (frame_end !== (k == 6)) begin n_err++; $display("FAIL stream_frame_end px%0d got %0b want %0b", k, frame_end, (k == 6)); end
            n_cmp++; if (hcount !== 2'(k % 3)) begin n_err++; $display("FAIL stream_hcount px%0d got %0d want %0d", k, hcount, k % 3); end
            n_cmp++; if (vcount !== 1'((k / 3) % 2)) begin n_err++; $display("FAIL stream_vcount px%0d got %0d want %0d", k, vcount, (k / 3) % 2); end
        end
        step();
        n_cmp++; if ({line_end, frame_end} !== 2'b00) begin n_err++; $display("FAIL stream_pulse_width got %b want 00", {line_end, frame_end}); end
    endtask

    task automatic test_abort();
        test_reset();
        run_pixel();
        pix_valid  = 1'b1;
        cost_ready = 1'b1;
        step();
        pix_valid = 1'b0;
        step();
        step();
        n_cmp++; if (disp !== 2'd2 || hcount !== 2'd1) begin n_err++; $display("FAIL abort_setup got d%0d h%0d want d2 h1", disp, hcount); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || cost_req !== 1'b0) begin n_err++; $display("FAIL abort_idle got busy%0b req%0b want 00", busy, cost_req); end
        n_cmp++; if (disp !== 2'd0 || hcount !== 2'd0 || vcount !== 1'd0) begin n_err++; $display("FAIL abort_zero got d%0d h%0d v%0d want 000", disp, hcount, vcount); end
        n_cmp++; if ({line_end, frame_end} !== 2'b00) begin n_err++; $display("FAIL abort_no_pulse got %b want 00", {line_end, frame_end}); end
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        n_cmp++; if (cost_req !== 1'b1 || disp !== 2'd0 || hcount !== 2'd0 || vcount !== 1'd0) begin n_err++; $display("FAIL abort_restart got r%0b d%0d h%0d v%0d want r1 d0 h0 v0", cost_req, disp, hcount, vcount); end
        repeat (MAX_DISP) step();
        run_pixel();
        // Abort on the final request of a line: no line_end, position cleared.
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        repeat (MAX_DISP - 1) step();
        n_cmp++; if (disp !== 2'd3 || hcount !== 2'd2) begin n_err++; $display("FAIL abort_eol_setup got d%0d h%0d want d3 h2", disp, hcount); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if (line_end !== 1'b0 || hcount !== 2'd0 || vcount !== 1'd0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_eol got le%0b h%0d v%0d b%0b want 0000", line_end, hcount, vcount, busy); end
    endtask

    task automatic test_abort_idle();
        abort     = 1'b1;
        pix_valid = 1'b1;
        #1;
        n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL abort_idle_ready got %0b want 0", pix_ready); end
        step();
        n_cmp++; if (busy !== 1'b0 || cost_req !== 1'b0) begin n_err++; $display("FAIL abort_idle_take got busy%0b req%0b want 00", busy, cost_req); end
        abort     = 1'b0;
        pix_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bit exp_req;
        bit exp_ready;
        int exp_disp;
        bit drained;
        test_reset();
        pix_valid  = 1'b1;
        cost_ready = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
`ifdef BACK2BACK_EN
            exp_req   = 1'b1;
            exp_disp  = i % 4;
            exp_ready = (i % 4 == 3);
`else
            exp_req   = (i % 5 != 4);
            exp_disp  = (i % 5 == 4) ? 0 : i % 5;
            exp_ready = (i % 5 == 4);
`endif
            n_cmp++; if (cost_req !== exp_req) begin n_err++; $display("FAIL b2b_req cyc%0d got %0b want %0b", i, cost_req, exp_req); end
            n_cmp++; if (disp !== 2'(exp_disp)) begin n_err++; $display("FAIL b2b_disp cyc%0d got %0d want %0d", i, disp, exp_disp); end
            n_cmp++; if (pix_ready !== exp_ready) begin n_err++; $display("FAIL b2b_ready cyc%0d got %0b want %0b", i, pix_ready, exp_ready); end
            step();
        end
        pix_valid = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            if (busy === 1'b0) drained = 1'b1;
            else step();
        end
        n_cmp++; if (!drained) begin n_err++; $display("FAIL b2b_drain timeout busy=%0b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_stream();
        test_abort();
        test_abort_idle();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/disparity_sweep_ctrl.md
Name: disparity_sweep_ctrl

Overview:
Sequencer for the stereo block-matching cost datapath. For each accepted left-image pixel, it sweeps disparity 0..MAX_DISP-1 and issues one cost request per disparity. The cost unit can apply backpressure to each request. The block also tracks pixel column/row, flags the last and next-to-last disparity of a pixel, and pulses line-end and frame-end markers. It sits between the pixel ingest stream and the cost/argmin pipeline.

Parameters:
MAX_DISP, 16, disparities swept per pixel; must be >= 2.
H_ACTIVE, 320, pixels per line.
V_ACTIVE, 240, lines per frame.

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
abort_in  input  1  synchronous abort; returns block to idle and zeroes position
pix_valid_in  input  1  pixel available from ingest
pix_ready_out  output  1  controller accepts pixel this cycle
cost_req_out  output  1  cost request valid
cost_ready_in  input  1  cost unit accepts request this cycle
cost_disp_out  output  $clog2(MAX_DISP)  disparity of current request
cost_hcount_out  output  $clog2(H_ACTIVE)  column of current pixel
cost_vcount_out  output  $clog2(V_ACTIVE)  row of current pixel
disp_almost_last_out  output  1  current request has disparity MAX_DISP-2
disp_last_out  output  1  current request has disparity MAX_DISP-1
line_end_out  output  1  one-cycle pulse: last request of a line accepted
frame_end_out  output  1  one-cycle pulse: last request of a frame accepted
busy_out  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; disp, hcount, vcount = 0; all outputs 0 except pix_ready_out = 1.
- States:
  - IDLE: pix_ready_out = !abort_in. On pix_valid_in & pix_ready_out: disp := 0 and go to SWEEP (request appears the next cycle).
  - SWEEP: cost_req_out = 1. disp, hcount and vcount are held stable until cost_ready_in.
- Accepted request (cost_req_out & cost_ready_in) with disp < MAX_DISP-1: disp += 1.
- Accepted request with disp == MAX_DISP-1:
  - disp := 0; go to IDLE.
  - hcount += 1; when hcount == H_ACTIVE-1 it wraps to 0, vcount += 1, and line_end_out pulses.
  - When vcount also == V_ACTIVE-1, vcount wraps to 0 and frame_end_out pulses alongside line_end_out.
- Pulses are registered and assert in the cycle after the acceptance.
- Throughput: MAX_DISP+1 cycles per pixel with cost_ready_in held high.
- disp_almost_last_out and disp_last_out are combinational from disp, qualified by cost_req_out.
- abort_in (any state): next cycle state = IDLE, counters = 0, no line_end/frame_end pulse, and no pixel accepted in that cycle. Abort overrides simultaneous acceptance.
- cost_ready_in without cost_req_out: ignored.
- pix_valid_in while busy: not accepted, because ready is low. Ingest holds the pixel.

Optional Feature:
BACK2BACK_EN
- Defined: pix_ready_out is also high in SWEEP when disp == MAX_DISP-1 & cost_ready_in & !abort_in. A pixel accepted then keeps state in SWEEP with disp := 0, with no bubble, giving MAX_DISP cycles per pixel. Position counters update as above.
- Undefined: ready only in IDLE; one idle bubble per pixel.

Decomposition:
- Package depth_sched_pkg: state enum (IDLE, SWEEP), width localparams derived from MAX_DISP/H_ACTIVE/V_ACTIVE.
- Sub-module wrap_counter (params MAX_COUNT):
  - Inputs inc_in, clr_in; outputs count_out, at_max_out, at_almost_out.
  - Wraps to 0 on inc at MAX_COUNT-1; async active-low reset.
  - Instantiated for disparity, column and row.

Test Plan:
- MAX_DISP=4, H=3, V=2, cost_ready_in high, one pixel: disp 0,1,2,3 on consecutive cycles; almost_last with disp=2, last with disp=3; hcount 0→1; busy_out drops after 4 requests.
- Same params, cost_ready_in low for 3 cycles at disp=1: cost_disp_out stays 1 and cost_req_out stays high, then the sweep resumes at disp 2.
- Stream 6 pixels: line_end_out pulses after pixels 3 and 6; frame_end_out pulses only after pixel 6; hcount/vcount return to 0/0.
- abort_in asserted at disp=2 of pixel 2: next cycle IDLE, all counters 0, no pulses; next pixel starts at h=0, v=0.
- abort_in and pix_valid_in together in IDLE: pix_ready_out=0, pixel not accepted, state stays IDLE.
- BACK2BACK_EN, continuous pix_valid_in: pixels every 4 cycles, disp sequence 0,1,2,3,0,1..., no bubble; without the macro a 1-cycle gap appears.
